timer_core: RTL and testbench
=============================

// Module: timer_core
// PURPOSE
// Kitchen-timer countdown engine feeding the 4-digit seven-segment display stage.
// Holds an MM:SS value, lets the user set it with buttons, counts down once per
// second from the board clock, and raises an alarm at 00:00. Outputs four 4-bit
// digit codes (0-9 = numeral, 4'hF = blank) consumed directly by the display mux.
// PARAMETERS
// TICK_DIV    100_000_000  sclk cycles per countdown second (1 s at 100 MHz)
// BLINK_DIV   50_000_000   sclk cycles per alarm blink half-period
// ALARM_SECS  10           alarm duration in whole seconds before auto-return to SET
// PORTS
// sclk        in   1  board clock; all logic on rising edge
// reset       in   1  synchronous, active-high reset
// btn_start   in   1  debounced level; start/pause/resume/ack
// btn_min     in   1  debounced level; minute increment (SET only)
// btn_sec     in   1  debounced level; second increment (SET only)
// btn_clear   in   1  debounced level; return to SET with 00:00
// dleft       out  4  minutes tens (0-9, or 4'hF blank)
// dmidleft    out  4  minutes ones
// dmidright   out  4  seconds tens (0-5)
// dright      out  4  seconds ones
// running     out  1  high in RUN
// alarm       out  1  high in ALARM
// BEHAVIOUR
// - Reset: state=SET, time=00:00, all digit outputs 4'd0, running=0, alarm=0,
//   prescaler/blink/alarm counters=0, button history regs=0 (held button after
//   reset release does NOT fire).
// - Buttons: rising-edge detected against 1-cycle-old registered copy; holding a
//   button yields exactly one event. Event acts on next clock edge; outputs are
//   registered, so change is visible 1 cycle after the edge-detect cycle.
// - Event priority in one cycle: clear > start > min > sec; min and sec together
//   in SET both apply.
// - Time stored as 4 BCD digits; minutes 00-99, seconds 00-59.
// - States: SET, RUN, PAUSE, ALARM.
//   SET:   min: minutes +1, 99->00. sec: seconds +1, 59->00, no carry to minutes.
//          start: time!=00:00 -> RUN, prescaler cleared; time==00:00 -> stay SET.
//   RUN:   prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 wraps and time -1 s
//          (BCD borrow: xx:00 -> (xx-1):59; ones 0 -> 9 with tens borrow).
//          If the decrement yields 00:00 -> ALARM same edge. start -> PAUSE.
//          min/sec ignored.
//   PAUSE: time and prescaler frozen (prescaler value retained). start -> RUN,
//          prescaler resumes from retained value. min/sec ignored.
//   ALARM: alarm=1; time=00:00; blink counter wraps at BLINK_DIV-1 and toggles
//          blank phase; blank phase drives all four digits to 4'hF, else 0,0,0,0.
//          Entry: blank phase=0 (digits show 00:00). Each 2*BLINK_DIV cycles counts
//          one alarm second; after ALARM_SECS seconds -> SET. start -> SET.
//   clear in any state -> SET, time=00:00, counters cleared, alarm=0.
// - running = (state==RUN); alarm = (state==ALARM); both registered with state.
// - reset asserted mid-RUN/ALARM overrides everything next edge (reset values).
// - Outputs outside ALARM always reflect stored BCD time, never 4'hF.
// TESTING (TICK_DIV=4, BLINK_DIV=2, ALARM_SECS=2 for sim)
// 1 reset, btn_min x3, btn_sec x2 pulses -> digits 0,3,0,2; running=0.
// 2 SET 00:59, btn_sec -> 00:00 (no carry); SET 99:xx, btn_min -> 00:xx.
// 3 SET 01:00, start -> running=1; after 4 cycles -> 00:59; 59 s more -> 00:00,
//   alarm=1, running=0 on the same edge.
// 4 RUN, start at prescaler=2 -> PAUSE, digits frozen 20 cycles; start -> next
//   decrement after exactly 2 cycles.
// 5 ALARM: digits toggle 0000 / FFFF every 2 cycles; after 8 cycles -> SET, 00:00.
// 6 start at 00:00 stays SET; clear+start same cycle in RUN -> SET 00:00; button
//   held 50 cycles counts once; reset mid-RUN -> all outputs reset values.

Source files
------------

// File: rtl/timer_core.sv
// Kitchen-timer countdown engine: BCD MM:SS set/run/pause/alarm control with
// button edge detection and registered digit codes for the display mux.
module timer_core #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int BLINK_DIV  = 50_000_000,
    parameter int ALARM_SECS = 10
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic       btn_clear,
    output logic [3:0] dleft,
    output logic [3:0] dmidleft,
    output logic [3:0] dmidright,
    output logic [3:0] dright,
    output logic       running,
    output logic       alarm
);
    typedef enum logic [1:0] {ST_SET, ST_RUN, ST_PAUSE, ST_ALARM} state_t;

    localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
    localparam logic [31:0] ALARM_LAST = 32'(ALARM_SECS - 1);

    state_t      state_q, state_d;
    logic [3:0]  mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic [31:0] presc_q, presc_d, blink_q, blink_d, asec_q, asec_d;
    logic        blank_q, blank_d;
    logic [3:0]  btn_q, btn_d;
    logic        armed_q, armed_d;
    logic [15:0] disp_q, disp_d;
    logic        running_q, running_d, alarm_q, alarm_d;

    logic [3:0]  btn_now, ev;
    logic        ev_clear, ev_start, ev_min, ev_sec;
    logic [3:0]  dmt, dmo, dst, dso;
    logic        dec_zero;
    logic        time_zero;

    // armed_q masks the first cycle after reset so a button held through reset never fires
    assign btn_now = {btn_clear, btn_start, btn_min, btn_sec};
    assign ev      = armed_q ? (btn_now & ~btn_q) : 4'b0000;
    assign {ev_clear, ev_start, ev_min, ev_sec} = ev;
    assign time_zero = ({mt_q, mo_q, st_q, so_q} == 16'h0000);

    always_comb begin
        dmt = mt_q;
        dmo = mo_q;
        dst = st_q;
        dso = so_q;
        if (so_q != 4'd0) begin
            dso = so_q - 4'd1;
        end else begin
            dso = 4'd9;
            if (st_q != 4'd0) begin
                dst = st_q - 4'd1;
            end else begin
                dst = 4'd5;
                if (mo_q != 4'd0) begin
                    dmo = mo_q - 4'd1;
                end else begin
                    dmo = 4'd9;
                    dmt = mt_q - 4'd1;
                end
            end
        end
    end

    assign dec_zero = ({dmt, dmo, dst, dso} == 16'h0000);

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        presc_d = presc_q;
        blink_d = blink_q;
        asec_d  = asec_q;
        blank_d = blank_q;
        btn_d   = btn_now;
        armed_d = 1'b1;

        if (ev_clear) begin
            state_d = ST_SET;
            {mt_d, mo_d, st_d, so_d} = 16'h0000;
            presc_d = '0;
            blink_d = '0;
            asec_d  = '0;
            blank_d = 1'b0;
        end else begin
            case (state_q)
                ST_SET: begin
                    if (ev_start) begin
                        if (!time_zero) begin
                            state_d = ST_RUN;
                            presc_d = '0;
                        end
                    end else begin
                        if (ev_min) begin
                            if (mo_q == 4'd9) begin
                                mo_d = 4'd0;
                                mt_d = (mt_q == 4'd9) ? 4'd0 : mt_q + 4'd1;
                            end else begin
                                mo_d = mo_q + 4'd1;
                            end
                        end
                        if (ev_sec) begin
                            if (so_q == 4'd9) begin
                                so_d = 4'd0;
                                st_d = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
                            end else begin
                                so_d = so_q + 4'd1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (ev_start) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == TICK_LAST) begin
                        presc_d = '0;
                        {mt_d, mo_d, st_d, so_d} = {dmt, dmo, dst, dso};
                        if (dec_zero) begin
                            state_d = ST_ALARM;
                            blink_d = '0;
                            asec_d  = '0;
                            blank_d = 1'b0;
                        end
                    end else begin
                        presc_d = presc_q + 32'd1;
                    end
                end
                ST_PAUSE: begin
                    if (ev_start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_ALARM: begin
                    if (ev_start) begin
                        state_d = ST_SET;
                        blink_d = '0;
                        asec_d  = '0;
                        blank_d = 1'b0;
                    end else if (blink_q == BLINK_LAST) begin
                        blink_d = '0;
                        blank_d = ~blank_q;
                        // a blank->lit transition closes one full blink period, i.e. one alarm second
                        if (blank_q) begin
                            if (asec_q == ALARM_LAST) begin
                                state_d = ST_SET;
                                asec_d  = '0;
                                blank_d = 1'b0;
                            end else begin
                                asec_d = asec_q + 32'd1;
                            end
                        end
                    end else begin
                        blink_d = blink_q + 32'd1;
                    end
                end
                default: state_d = ST_SET;
            endcase
        end

        disp_d    = (state_d == ST_ALARM && blank_d) ? 16'hFFFF : {mt_d, mo_d, st_d, so_d};
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q   <= ST_SET;
            mt_q      <= 4'd0;
            mo_q      <= 4'd0;
            st_q      <= 4'd0;
            so_q      <= 4'd0;
            presc_q   <= '0;
            blink_q   <= '0;
            asec_q    <= '0;
            blank_q   <= 1'b0;
            btn_q     <= 4'b0000;
            armed_q   <= 1'b0;
            disp_q    <= 16'h0000;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mt_q      <= mt_d;
            mo_q      <= mo_d;
            st_q      <= st_d;
            so_q      <= so_d;
            presc_q   <= presc_d;
            blink_q   <= blink_d;
            asec_q    <= asec_d;
            blank_q   <= blank_d;
            btn_q     <= btn_d;
            armed_q   <= armed_d;
            disp_q    <= disp_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    assign {dleft, dmidleft, dmidright, dright} = disp_q;
    assign running = running_q;
    assign alarm   = alarm_q;
endmodule

// File: tb/tb_timer_core.sv
// Scoreboard bench for timer_core: directed button sequences push timed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_timer_core;
    logic       sclk = 1'b0;
    logic       reset;
    logic       btn_start, btn_min, btn_sec, btn_clear;
    logic [3:0] dleft, dmidleft, dmidright, dright;
    logic       running, alarm;

    localparam logic [3:0] B_CLEAR = 4'b1000;
    localparam logic [3:0] B_START = 4'b0100;
    localparam logic [3:0] B_MIN   = 4'b0010;
    localparam logic [3:0] B_SEC   = 4'b0001;

    typedef struct {
        int          due;
        string       name;
        logic [15:0] dig;
        logic        run;
        logic        al;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    timer_core #(.TICK_DIV(4), .BLINK_DIV(2), .ALARM_SECS(2)) dut (
        .sclk(sclk), .reset(reset),
        .btn_start(btn_start), .btn_min(btn_min), .btn_sec(btn_sec), .btn_clear(btn_clear),
        .dleft(dleft), .dmidleft(dmidleft), .dmidright(dmidright), .dright(dright),
        .running(running), .alarm(alarm)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    // Monitor: pops every expectation whose due cycle has arrived and compares it
    initial begin
        exp_t e;
        logic [15:0] got;
        forever begin
            @(negedge sclk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                got = {dleft, dmidleft, dmidright, dright};
                compared++;
                if (e.due != cyc || got !== e.dig || running !== e.run || alarm !== e.al) begin
                    mismatched++;
                    $display("[TB] FAIL %s @cyc %0d (due %0d): got digits=%h running=%b alarm=%b, expected digits=%h running=%b alarm=%b",
                             e.name, cyc, e.due, got, running, alarm, e.dig, e.run, e.al);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int k, input logic [15:0] dig,
                               input logic run, input logic al);
        exp_t e;
        e.due  = cyc + k;
        e.name = name;
        e.dig  = dig;
        e.run  = run;
        e.al   = al;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] b, input int hold);
        {btn_clear, btn_start, btn_min, btn_sec} = b;
        repeat (hold) @(negedge sclk);
        {btn_clear, btn_start, btn_min, btn_sec} = 4'b0000;
        @(negedge sclk);
    endtask

    task automatic pressN(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(b, 1);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() > 0 && n < 2000) begin
            @(negedge sclk);
            n++;
        end
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending expectations, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        {btn_clear, btn_start, btn_sec} = 3'b000;
        btn_min = 1'b1;
        @(negedge sclk);
        checkOutput("reset_state", 1, 16'h0000, 1'b0, 1'b0);
        waitCycles(2);
        reset = 1'b0;
        waitCycles(3);
        btn_min = 1'b0;
        checkOutput("held_through_reset", 2, 16'h0000, 1'b0, 1'b0);
        waitDrain();

        pressN(B_MIN, 3);
        pressN(B_SEC, 2);
        checkOutput("set_0302", 1, 16'h0302, 1'b0, 1'b0);
        waitDrain();

        applyStimulus(B_CLEAR, 1);
        pressN(B_SEC, 59);
        checkOutput("sec_59", 1, 16'h0059, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(B_SEC, 1);
        checkOutput("sec_wrap_no_carry", 1, 16'h0000, 1'b0, 1'b0);
        waitDrain();
        pressN(B_MIN, 99);
        checkOutput("min_99", 1, 16'h9900, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(B_MIN, 1);
        checkOutput("min_wrap", 1, 16'h0000, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(B_MIN | B_SEC, 1);
        checkOutput("min_sec_together", 1, 16'h0101, 1'b0, 1'b0);
        waitDrain();

        // 01:00 countdown into alarm, then alarm blink and auto-return
        applyStimulus(B_CLEAR, 1);
        applyStimulus(B_MIN, 1);
        applyStimulus(B_START, 1);
        checkOutput("run_start", 1, 16'h0100, 1'b1, 1'b0);
        checkOutput("run_pre_tick", 2, 16'h0100, 1'b1, 1'b0);
        checkOutput("run_tick1", 3, 16'h0059, 1'b1, 1'b0);
        checkOutput("run_tick2", 7, 16'h0058, 1'b1, 1'b0);
        checkOutput("run_last_sec", 238, 16'h0001, 1'b1, 1'b0);
        for (int j = 0; j <= 8; j++) begin
            checkOutput($sformatf("alarm_step%0d", j), 239 + j,
                        (j < 8 && ((j / 2) % 2 == 1)) ? 16'hFFFF : 16'h0000,
                        1'b0, (j < 8) ? 1'b1 : 1'b0);
        end
        waitDrain();

        // pause at prescaler 2 and resume
        applyStimulus(B_CLEAR, 1);
        pressN(B_SEC, 5);
        applyStimulus(B_START, 1);
        waitCycles(1);
        applyStimulus(B_START, 1);
        checkOutput("pause_enter", 1, 16'h0005, 1'b0, 1'b0);
        checkOutput("pause_frozen10", 10, 16'h0005, 1'b0, 1'b0);
        checkOutput("pause_frozen20", 20, 16'h0005, 1'b0, 1'b0);
        waitCycles(20);
        checkOutput("resume_run", 1, 16'h0005, 1'b1, 1'b0);
        checkOutput("resume_pre_tick", 2, 16'h0005, 1'b1, 1'b0);
        checkOutput("resume_tick", 3, 16'h0004, 1'b1, 1'b0);
        checkOutput("resume_tick_next", 7, 16'h0003, 1'b1, 1'b0);
        applyStimulus(B_START, 1);
        waitDrain();

        reset = 1'b1;
        checkOutput("reset_mid_run", 1, 16'h0000, 1'b0, 1'b0);
        waitCycles(2);
        reset = 1'b0;
        checkOutput("after_reset_idle", 5, 16'h0000, 1'b0, 1'b0);
        waitDrain();

        applyStimulus(B_START, 1);
        checkOutput("start_at_zero", 1, 16'h0000, 1'b0, 1'b0);
        checkOutput("start_at_zero_later", 4, 16'h0000, 1'b0, 1'b0);
        waitDrain();

        pressN(B_MIN, 2);
        applyStimulus(B_START, 1);
        checkOutput("run_0200", 1, 16'h0200, 1'b1, 1'b0);
        waitCycles(2);
        applyStimulus(B_CLEAR | B_START, 1);
        checkOutput("clear_beats_start", 1, 16'h0000, 1'b0, 1'b0);
        checkOutput("clear_stays_set", 8, 16'h0000, 1'b0, 1'b0);
        waitDrain();

        applyStimulus(B_SEC, 50);
        checkOutput("held_counts_once", 1, 16'h0001, 1'b0, 1'b0);
        waitDrain();

        // 00:01 reaches alarm on the first tick; start acknowledges it early
        applyStimulus(B_START, 1);
        checkOutput("short_alarm", 3, 16'h0000, 1'b0, 1'b1);
        waitCycles(4);
        applyStimulus(B_START, 1);
        checkOutput("alarm_ack", 1, 16'h0000, 1'b0, 1'b0);
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
